// File: rtl/pipeline_control_unit_pkg.sv
// pipeline_control_types: types and defaults shared by the pipeline control unit
// and its cache-maintenance sequencer.
//   ctrl_state_e           - top-level sequencer state
//   double_word            - 64-bit address/data word
//   DEFAULT_FLUSH_TIMEOUT  - default cycle budget for a cache done pulse
package pipeline_control_types;

    typedef logic [63:0] double_word;

    typedef enum logic [2:0] {
        StRun,
        StRedirect,
        StFenceD,
        StFenceI,
        StDrain,
        StHalted
    } ctrl_state_e;

    localparam int unsigned DEFAULT_FLUSH_TIMEOUT = 1024;

endpackage

// File: rtl/pipeline_control_unit_cache_maint.sv
// cache_maint_sequencer: request/done handshake and timeout for the two FENCE.I
// cache-maintenance phases (D-cache writeback, then I-cache invalidate).
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   in_fence_d          - top FSM is in the D-cache writeback phase
//   in_fence_i          - top FSM is in the I-cache invalidate phase
//   dcache_wb_done      - D-cache writeback complete pulse
//   icache_inv_done     - I-cache invalidate complete pulse
//   dcache_wb_req       - level request while in the writeback phase
//   icache_inv_req      - level request while in the invalidate phase
//   phase_done          - current phase finishes this cycle (done or timeout)
//   timed_out           - current phase finishes by timeout, no done seen
module cache_maint_sequencer
    import pipeline_control_types::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = DEFAULT_FLUSH_TIMEOUT,
    parameter int unsigned CNT_W         = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic in_fence_d,
    input  logic in_fence_i,
    input  logic dcache_wb_done,
    input  logic icache_inv_done,
    output logic dcache_wb_req,
    output logic icache_inv_req,
    output logic phase_done,
    output logic timed_out
);

    logic [CNT_W-1:0] timer_q;
    logic             active;
    logic             done_seen;
    logic             expired;

    // The phase flags come straight from the registered top state, so the
    // requests drop the cycle after reset or phase exit.
    assign dcache_wb_req  = in_fence_d;
    assign icache_inv_req = in_fence_i;

    assign active    = in_fence_d || in_fence_i;
    assign done_seen = (in_fence_d && dcache_wb_done) || (in_fence_i && icache_inv_done);
    // timer_q counts completed cycles in the phase; the last allowed cycle is
    // the one where it reads FLUSH_TIMEOUT-1.
    assign expired    = active && (timer_q == CNT_W'(FLUSH_TIMEOUT - 1));
    assign phase_done = done_seen || expired;
    assign timed_out  = expired && !done_seen;

    // Cleared whenever a phase ends so each phase entry starts from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q <= '0;
        end else if (!active || phase_done) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: sequences front-end redirects, FENCE.I cache
// maintenance and end-of-program halt for events resolved in EX.
// Ports:
//   clk, rst                          - clock, synchronous active-low reset
//   ex_valid, mem_stall               - EX event is accepted when valid and not stalled
//   ex_is_branch/_fencei/_final       - event kind (final > fencei > branch)
//   ex_branch_taken                   - outcome; both outcomes redirect to ex_target
//   ex_target                         - resolved target or PC+4
//   dcache_wb_done, icache_inv_done   - cache maintenance done pulses
//   pc_redirect_valid/_target         - one-cycle PC load
//   branch_reset                      - one-cycle release of decode's branch wait
//   frontend_hold                     - fetch must not issue
//   dcache_wb_req, icache_inv_req     - level cache maintenance requests
//   halted, flush_error               - sticky status
//   redirect_count                    - redirects issued, wraps
module pipeline_control_unit
    import pipeline_control_types::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = DEFAULT_FLUSH_TIMEOUT,
    parameter int unsigned DRAIN_CYCLES  = 3,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_branch_taken,
    input  double_word       ex_target,
    input  logic             ex_is_fencei,
    input  logic             ex_is_final,
    input  logic             mem_stall,
    input  logic             dcache_wb_done,
    input  logic             icache_inv_done,
    output logic             pc_redirect_valid,
    output double_word       pc_redirect_target,
    output logic             branch_reset,
    output logic             frontend_hold,
    output logic             dcache_wb_req,
    output logic             icache_inv_req,
    output logic             halted,
    output logic             flush_error,
    output logic [CNT_W-1:0] redirect_count
);

    ctrl_state_e      state_q;
    logic [CNT_W-1:0] drain_q;
    logic             ex_event;
    logic             maint_done;
    logic             maint_timeout;
    logic             unused_branch_taken;

    // Taken and not-taken both redirect: EX already resolved the address.
    assign unused_branch_taken = ex_branch_taken;

    assign ex_event      = ex_valid && !mem_stall;
    assign frontend_hold = (state_q != StRun) || ex_event;

    cache_maint_sequencer #(
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_cache_maint (
        .clk             (clk),
        .rst             (rst),
        .in_fence_d      (state_q == StFenceD),
        .in_fence_i      (state_q == StFenceI),
        .dcache_wb_done  (dcache_wb_done),
        .icache_inv_done (icache_inv_done),
        .dcache_wb_req   (dcache_wb_req),
        .icache_inv_req  (icache_inv_req),
        .phase_done      (maint_done),
        .timed_out       (maint_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= StRun;
            drain_q            <= '0;
            pc_redirect_valid  <= 1'b0;
            pc_redirect_target <= '0;
            branch_reset       <= 1'b0;
            halted             <= 1'b0;
            flush_error        <= 1'b0;
            redirect_count     <= '0;
        end else begin
            pc_redirect_valid <= 1'b0;
            branch_reset      <= 1'b0;
            if (maint_timeout) begin
                flush_error <= 1'b1;
            end

            unique case (state_q)
                StRun: begin
                    if (ex_event) begin
                        if (ex_is_final) begin
                            drain_q <= CNT_W'(DRAIN_CYCLES);
                            state_q <= StDrain;
                        end else if (ex_is_fencei) begin
                            pc_redirect_target <= ex_target;
                            state_q            <= StFenceD;
                        end else if (ex_is_branch) begin
                            pc_redirect_target <= ex_target;
                            pc_redirect_valid  <= 1'b1;
                            branch_reset       <= 1'b1;
                            redirect_count     <= redirect_count + CNT_W'(1);
                            state_q            <= StRedirect;
                        end
                    end
                end
                StRedirect: begin
                    state_q <= StRun;
                end
                StFenceD: begin
                    if (maint_done) begin
                        state_q <= StFenceI;
                    end
                end
                StFenceI: begin
                    if (maint_done) begin
                        pc_redirect_valid <= 1'b1;
                        branch_reset      <= 1'b1;
                        redirect_count    <= redirect_count + CNT_W'(1);
                        state_q           <= StRedirect;
                    end
                end
                StDrain: begin
                    // Halt on the advancing cycle that uses up the last count.
                    if (!mem_stall) begin
                        if (drain_q <= CNT_W'(1)) begin
                            halted  <= 1'b1;
                            state_q <= StHalted;
                        end else begin
                            drain_q <= drain_q - CNT_W'(1);
                        end
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

endmodule
